// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types, default parameters and width helper for the UART TX arbiter.
package uart_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 16;
  localparam int WR_GAP_DEF    = 1;
  localparam int TIMEOUT_DEF   = 64;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the transmitter write port.
// master = requesters/transmitter side, slave = arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_thr;
  logic [7:0]           tx_data;
  logic                 tx_write_en;
  logic                 tx_en;

  modport master (
    output req_valid, req_data, req_last, tx_thr,
    input  req_ready, tx_data, tx_write_en, tx_en
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_thr,
    output req_ready, tx_data, tx_write_en, tx_en
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] pick_o,
  output logic                       any_o
);
  localparam int IDW = $clog2(NUM_REQ);

  // Doubling the vector turns the wrap-around search into a linear one.
  logic [2*NUM_REQ-1:0] dbl;
  assign dbl = {req_i, req_i};

  // Scan downwards so the lowest offset from ptr_i wins.
  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (dbl[int'(ptr_i) + i]) begin
        any_o  = 1'b1;
        pick_o = IDW'((int'(ptr_i) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmitter FIFO push port among NUM_REQ byte streams.
//   state     | meaning
//   ARB_IDLE  | no owner; arbitrate when enabled and any request is pending
//   ARB_GRANT | grant_q owns the port until last byte, burst limit or timeout
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int WR_GAP    = WR_GAP_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  uart_tx_arbiter_if.slave           bus,
  input  logic                       cfg_tx_en,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = clog2_min1(MAX_BURST);
  localparam int GW  = clog2_min1(WR_GAP + 1);
  localparam int TW  = clog2_min1(TIMEOUT);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [TW-1:0]    to_q, to_d;
  logic             err_d;
  logic             err_q;
  logic             busy_q;
  logic             tx_we_q;
  logic [7:0]       tx_data_q;
  logic [NUM_REQ-1:0] ready;
  logic             beat;
  logic [IDW-1:0]   pick;
  logic             any;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (bus.req_valid),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick),
    .any_o  (any)
  );

  // Next-state, counters and accept decision.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    to_d     = to_q;
    err_d    = 1'b0;
    ready    = '0;
    beat     = 1'b0;
    gap_d    = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    case (state_q)
      ARB_IDLE: begin
        if (cfg_tx_en && any) begin
          state_d = ARB_GRANT;
          grant_d = pick;
          burst_d = '0;
          to_d    = '0;
        end
      end
      ARB_GRANT: begin
        if (cfg_tx_en && bus.tx_thr && gap_q == '0) ready[grant_q] = 1'b1;
        beat = bus.req_valid[grant_q] && ready[grant_q];
        if (beat) begin
          gap_d = GW'(WR_GAP);
          to_d  = '0;
          if (bus.req_last[grant_q] || burst_q == BW'(MAX_BURST - 1)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            burst_d  = '0;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end else if (!bus.req_valid[grant_q]) begin
          if (to_q == TW'(TIMEOUT - 1)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            burst_d  = '0;
            to_d     = '0;
            err_d    = 1'b1;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, counters and registered transmitter outputs; reset drops any pending write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      burst_q   <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_we_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      gap_q    <= gap_d;
      to_q     <= to_d;
      err_q    <= err_d;
      busy_q   <= (state_d == ARB_GRANT);
      tx_we_q  <= beat;
      if (beat) tx_data_q <= bus.req_data[{grant_q, 3'b000} +: 8];
    end
  end

  assign bus.req_ready   = ready;
  assign bus.tx_write_en = tx_we_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_en       = cfg_tx_en;
  assign grant_id        = grant_q;
  assign busy            = busy_q;
  assign err_timeout     = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// message-level reference model of the arbiter.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int MB  = 16;
  localparam int GAP = 1;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cfg_tx_en = 1'b0;
  logic [1:0] grant_id;
  logic       busy;
  logic       err_timeout;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .WR_GAP(GAP), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .cfg_tx_en   (cfg_tx_en),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester side: pending bytes {last, data} per requester.
  logic [8:0] rq [N][$];
  bit   hold [N];
  int   vprob = 100;

  // Reference model: owner, position in message-burst, idle wait, pending write.
  int         m_busy, m_owner, m_ptr, m_cnt, m_gap, m_idle, m_wr, m_err;
  logic [7:0] m_wdata;

  // Observations of the DUT.
  int glog [$];
  int prev_busy = 0;
  int err_seen  = 0;
  int cyc       = 0;
  int last_wr   = -100;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    m_gap = 0; m_idle = 0; m_wr = 0; m_err = 0; m_wdata = 8'h00;
    prev_busy = 0; last_wr = -100;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_valid[i]        = !hold[i] && ($urandom_range(99) < vprob);
        bus.req_data[8*i +: 8]  = rq[i][0][7:0];
        bus.req_last[i]         = rq[i][0][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[8*i +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic push_msg(input int r, input int len, input bit with_last);
    for (int k = 0; k < len; k++)
      rq[r].push_back({with_last && (k == len - 1), 8'($urandom)});
    drive_inputs();
  endtask

  task automatic release_grant();
    m_busy = 0;
    m_ptr  = (m_owner + 1) % N;
    m_cnt  = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, re-drive after the rising edge.
  task automatic cycle();
    logic [N-1:0] rdy;
    logic [8:0]   f;
    bit           beat;
    bit           found;
    int           g;
    @(negedge clk);
    g   = m_owner;
    rdy = '0;
    if (m_busy != 0 && cfg_tx_en && bus.tx_thr && m_gap == 0) rdy[g] = 1'b1;
    chk("req_ready",   32'(bus.req_ready),   32'(rdy));
    chk("tx_write_en", 32'(bus.tx_write_en), 32'(m_wr));
    chk("tx_data",     32'(bus.tx_data),     32'(m_wdata));
    chk("grant_id",    32'(grant_id),        32'(m_owner));
    chk("busy",        32'(busy),            32'(m_busy));
    chk("err_timeout", 32'(err_timeout),     32'(m_err));
    chk("tx_en",       32'(bus.tx_en),       32'(cfg_tx_en));
    if (bus.tx_write_en) begin
      chk("wr_spacing", 32'((cyc - last_wr) >= GAP + 1), 32'd1);
      last_wr = cyc;
    end
    if (busy && prev_busy == 0) glog.push_back(int'(grant_id));
    prev_busy = int'(busy);
    if (err_timeout) err_seen++;

    beat  = rdy[g] && bus.req_valid[g];
    m_err = 0;
    m_wr  = int'(beat);
    if (m_gap > 0) m_gap--;
    if (m_busy == 0) begin
      if (cfg_tx_en && bus.req_valid != '0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && bus.req_valid[(m_ptr + k) % N]) begin
            found   = 1;
            m_owner = (m_ptr + k) % N;
          end
        end
        m_busy = 1; m_cnt = 0; m_idle = 0;
      end
    end else if (beat) begin
      f       = rq[g].pop_front();
      m_wdata = f[7:0];
      m_gap   = GAP;
      m_idle  = 0;
      m_cnt++;
      if (f[8] || m_cnt == MB) release_grant();
    end else if (!bus.req_valid[g]) begin
      m_idle++;
      if (m_idle == TO) begin
        release_grant();
        m_err  = 1;
        m_idle = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_write_en", 32'(bus.tx_write_en), 32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),     32'd0);
    chk("rst_ready",    32'(bus.req_ready),   32'd0);
    chk("rst_busy",     32'(busy),            32'd0);
    chk("rst_grant",    32'(grant_id),        32'd0);
    chk("rst_err",      32'(err_timeout),     32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive_inputs();
  endtask

  task automatic chk_glog(input string tag, input int n, input int e0, input int e1,
                          input int e2, input int e3);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_ngrants"}, 32'(glog.size()), 32'(n));
    for (int k = 0; k < n && k < glog.size(); k++)
      chk($sformatf("%s_grant%0d", tag, k), 32'(glog[k]), 32'(e[k]));
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  initial begin
    int  e0;
    bit  seen;
    bus.tx_thr = 1'b1;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    drive_inputs();
    do_reset();
    cfg_tx_en = 1'b1;

    // Four 3-byte messages: grants in order 0..3.
    glog.delete();
    for (int r = 0; r < N; r++) push_msg(r, 3, 1'b1);
    run(40);
    chk_glog("s1", 4, 0, 1, 2, 3);
    chk("s1_drained", 32'(pending()), 32'd0);

    // Burst limit: requester 2 sends 20 bytes, requester 3 interleaves.
    glog.delete();
    push_msg(2, 20, 1'b1);
    push_msg(3, 2, 1'b1);
    run(90);
    chk_glog("s2", 3, 2, 3, 2, 0);
    chk("s2_drained", 32'(pending()), 32'd0);

    // Transmitter full mid-message: grant held, no timeout.
    glog.delete();
    e0 = err_seen;
    push_msg(0, 6, 1'b1);
    run(4);
    bus.tx_thr = 1'b0;
    run(10);
    bus.tx_thr = 1'b1;
    run(20);
    chk_glog("s3", 1, 0, 0, 0, 0);
    chk("s3_no_timeout", 32'(err_seen - e0), 32'd0);
    chk("s3_drained", 32'(pending()), 32'd0);

    // Granted requester 1 stalls: timeout releases to requester 2.
    glog.delete();
    e0 = err_seen;
    push_msg(1, 4, 1'b1);
    push_msg(2, 2, 1'b1);
    run(3);
    hold[1] = 1'b1;
    drive_inputs();
    run(80);
    chk("s4_timeouts", 32'(err_seen - e0), 32'd1);
    chk_glog("s4", 2, 1, 2, 0, 0);
    hold[1] = 1'b0;
    drive_inputs();
    run(30);
    chk("s4_drained", 32'(pending()), 32'd0);

    // Pointer wrap after a release from requester 3.
    push_msg(3, 1, 1'b1);
    run(10);
    glog.delete();
    push_msg(3, 2, 1'b1);
    push_msg(0, 2, 1'b1);
    run(20);
    chk_glog("s5", 2, 0, 3, 0, 0);

    // Reset right after a beat discards the pending write.
    push_msg(1, 5, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (bus.tx_write_en) seen = 1'b1;
    end
    chk("s6_beat_seen", 32'(seen), 32'd1);
    for (int i = 0; i < N; i++) rq[i].delete();
    do_reset();
    glog.delete();
    push_msg(2, 2, 1'b1);
    push_msg(0, 2, 1'b1);
    run(20);
    chk_glog("s6", 2, 0, 2, 0, 0);

    // Random traffic with gated valid, transmitter back-pressure and enable drops.
    vprob = 70;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(9) == 0) begin
        int r;
        r = $urandom_range(N - 1);
        if (rq[r].size() < 30) push_msg(r, $urandom_range(20, 1), 1'b1);
      end
      bus.tx_thr = ($urandom_range(99) < 85);
      cfg_tx_en  = ($urandom_range(99) < 95);
      cycle();
    end
    vprob      = 100;
    bus.tx_thr = 1'b1;
    cfg_tx_en  = 1'b1;
    drive_inputs();
    run(700);
    chk("rand_drained", 32'(pending()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
